// File: rtl/tetris_drop_scheduler.sv
// tetris_drop_scheduler
// Gravity scheduler for the Tetris core. It consumes the divided tick stream and
// decides when the falling piece moves down one row and when a landed piece
// locks. Each decision is issued to the game engine as a request/acknowledge
// handshake.
// Optional feature: define TETRIS_SOFT_DROP_EN to let a held soft_drop force a
// drop on every tick. Without it, soft_drop is ignored.

module tetris_drop_scheduler #(
   parameter int MAX_DIV    = 8,
   parameter int LEVEL_W    = 4,
   parameter int LOCK_TICKS = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               tick_in,
   input  logic [LEVEL_W-1:0] level,
   input  logic               soft_drop,
   input  logic               pause,
   input  logic               landed,
   input  logic               drop_ack,
   input  logic               lock_ack,
   output logic               drop_req,
   output logic               lock_req,
   output logic               overrun,
   output logic [1:0]         state_o
);

   localparam int TCNT_W = $clog2(MAX_DIV + 1);
   localparam int LCNT_W = $clog2(LOCK_TICKS + 1);

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      REQ       = 2'd1,
      LOCK_WAIT = 2'd2,
      LOCK_REQ  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
   logic [LCNT_W-1:0]   lcnt_q, lcnt_d;
   logic                dropReq_q, dropReq_d;
   logic                lockReq_q, lockReq_d;
   logic                overrun_q, overrun_d;

   logic                softDropActive;
   logic [TCNT_W-1:0]   divVal;
   logic                validTick;
   logic                tickFires;
   logic                divIsOne;
   logic                lockDone;

`ifdef TETRIS_SOFT_DROP_EN
   assign softDropActive = soft_drop;
`else
   logic unusedSoftDrop;
   assign unusedSoftDrop = soft_drop;
   assign softDropActive = 1'b0;
`endif

   assign validTick = tick_in & ~pause;

   // Drop interval: MAX_DIV - level, floored at 1; the comparison happens before
   // the subtraction so a level above MAX_DIV cannot underflow.
   always_comb begin
      divVal = TCNT_W'(1);
      if (!softDropActive && (int'({1'b0, level}) < MAX_DIV)) begin
         divVal = TCNT_W'(MAX_DIV - int'({1'b0, level}));
      end
   end

   assign tickFires = (int'(tcnt_q) + 1) >= int'(divVal);
   assign divIsOne  = (divVal == TCNT_W'(1));
   assign lockDone  = (int'(lcnt_q) + 1) == LOCK_TICKS;

   // Next-state logic: RUN counts ticks, REQ/LOCK_REQ hold a request until acked,
   // LOCK_WAIT counts ticks spent landed. An ack that coincides with a valid tick
   // restarts RUN with that tick already counted (tcnt was zero on entry).
   always_comb begin
      state_d   = state_q;
      tcnt_d    = tcnt_q;
      lcnt_d    = lcnt_q;
      dropReq_d = dropReq_q;
      lockReq_d = lockReq_q;
      overrun_d = overrun_q;
      unique case (state_q)
         RUN: begin
            if (validTick) begin
               if (tickFires) begin
                  tcnt_d = '0;
                  if (landed) begin
                     state_d = LOCK_WAIT;
                     lcnt_d  = '0;
                  end else begin
                     state_d   = REQ;
                     dropReq_d = 1'b1;
                  end
               end else begin
                  tcnt_d = tcnt_q + TCNT_W'(1);
               end
            end
         end
         REQ: begin
            if (drop_ack) begin
               dropReq_d = 1'b0;
               state_d   = RUN;
               tcnt_d    = '0;
               if (validTick) begin
                  if (divIsOne) begin
                     if (landed) begin
                        state_d = LOCK_WAIT;
                        lcnt_d  = '0;
                     end else begin
                        state_d   = REQ;
                        dropReq_d = 1'b1;
                     end
                  end else begin
                     tcnt_d = TCNT_W'(1);
                  end
               end
            end else if (validTick) begin
               overrun_d = 1'b1;
            end
         end
         LOCK_WAIT: begin
            // Pause freezes the FSM, so a slide-off is only acted on while running.
            if (!pause && !landed) begin
               state_d = RUN;
               tcnt_d  = '0;
            end else if (validTick) begin
               if (lockDone) begin
                  state_d   = LOCK_REQ;
                  lockReq_d = 1'b1;
                  lcnt_d    = '0;
               end else begin
                  lcnt_d = lcnt_q + LCNT_W'(1);
               end
            end
         end
         LOCK_REQ: begin
            if (lock_ack) begin
               lockReq_d = 1'b0;
               state_d   = RUN;
               tcnt_d    = '0;
               if (validTick) begin
                  if (divIsOne) begin
                     if (landed) begin
                        state_d = LOCK_WAIT;
                        lcnt_d  = '0;
                     end else begin
                        state_d   = REQ;
                        dropReq_d = 1'b1;
                     end
                  end else begin
                     tcnt_d = TCNT_W'(1);
                  end
               end
            end else if (validTick) begin
               overrun_d = 1'b1;
            end
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= RUN;
         tcnt_q    <= '0;
         lcnt_q    <= '0;
         dropReq_q <= 1'b0;
         lockReq_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         tcnt_q    <= tcnt_d;
         lcnt_q    <= lcnt_d;
         dropReq_q <= dropReq_d;
         lockReq_q <= lockReq_d;
         overrun_q <= overrun_d;
      end
   end

   assign drop_req = dropReq_q;
   assign lock_req = lockReq_q;
   assign overrun  = overrun_q;
   assign state_o  = state_q;

endmodule

// File: tb/tb_tetris_drop_scheduler.sv
// Testbench for tetris_drop_scheduler: randomized phases (fixed levels, soft
// drop, landing, slow acks, pause, full random with resets) compared every
// cycle against a behavioural gravity model.

module tb_tetris_drop_scheduler;

   localparam int MAX_DIV    = 8;
   localparam int LEVEL_W    = 4;
   localparam int LOCK_TICKS = 2;

`ifdef TETRIS_SOFT_DROP_EN
   localparam bit SOFT_EN = 1'b1;
`else
   localparam bit SOFT_EN = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               rst;
   logic               tick_in;
   logic [LEVEL_W-1:0] level;
   logic               soft_drop;
   logic               pause;
   logic               landed;
   logic               drop_ack;
   logic               lock_ack;
   logic               drop_req;
   logic               lock_req;
   logic               overrun;
   logic [1:0]         state_o;

   int compared   = 0;
   int mismatched = 0;

   // Reference model: phase 0 falling, 1 waiting for drop ack, 2 resting on the
   // stack, 3 waiting for lock ack.
   int refPhase;
   int elapsedTicks;
   int landedTicks;
   bit refDrop;
   bit refLock;
   bit refOverrun;

   // Stimulus phase: cycles, tick %, level (-1 random), soft %, pause %,
   // landed at start, landed flip %, ack %, reset per mille.
   typedef struct {
      int cycles;
      int tickPct;
      int levelSel;
      int softPct;
      int pausePct;
      int landedStart;
      int landFlipPct;
      int ackPct;
      int rstPerMille;
   } phase_t;

   phase_t phases[$];

   always #5 clk = ~clk;

   tetris_drop_scheduler #(
      .MAX_DIV   (MAX_DIV),
      .LEVEL_W   (LEVEL_W),
      .LOCK_TICKS(LOCK_TICKS)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .tick_in  (tick_in),
      .level    (level),
      .soft_drop(soft_drop),
      .pause    (pause),
      .landed   (landed),
      .drop_ack (drop_ack),
      .lock_ack (lock_ack),
      .drop_req (drop_req),
      .lock_req (lock_req),
      .overrun  (overrun),
      .state_o  (state_o)
   );

   // Number of valid ticks between drops for a given level and soft-drop key.
   function automatic int gravityInterval(input int lvl, input bit sd);
      if (SOFT_EN && sd) return 1;
      if (lvl >= MAX_DIV) return 1;
      return MAX_DIV - lvl;
   endfunction

   // One valid tick of falling: once enough ticks have elapsed the piece either
   // requests a drop or, if resting, starts its lock delay.
   task automatic gravityTick();
      elapsedTicks = elapsedTicks + 1;
      if (elapsedTicks >= gravityInterval(int'(level), soft_drop)) begin
         elapsedTicks = 0;
         if (landed) begin
            refPhase    = 2;
            landedTicks = 0;
         end else begin
            refPhase = 1;
            refDrop  = 1'b1;
         end
      end
   endtask

   // Advance the model by one clock using the inputs currently driven.
   task automatic modelStep();
      bit vt;
      vt = tick_in && !pause;
      if (rst) begin
         refPhase     = 0;
         elapsedTicks = 0;
         landedTicks  = 0;
         refDrop      = 1'b0;
         refLock      = 1'b0;
         refOverrun   = 1'b0;
      end else begin
         case (refPhase)
            0: if (vt) gravityTick();
            1: begin
               if (drop_ack) begin
                  refDrop      = 1'b0;
                  refPhase     = 0;
                  elapsedTicks = 0;
                  if (vt) gravityTick();
               end else if (vt) begin
                  refOverrun = 1'b1;
               end
            end
            2: begin
               if (!pause && !landed) begin
                  refPhase     = 0;
                  elapsedTicks = 0;
               end else if (vt) begin
                  landedTicks = landedTicks + 1;
                  if (landedTicks == LOCK_TICKS) begin
                     refPhase = 3;
                     refLock  = 1'b1;
                  end
               end
            end
            default: begin
               if (lock_ack) begin
                  refLock      = 1'b0;
                  refPhase     = 0;
                  elapsedTicks = 0;
                  if (vt) gravityTick();
               end else if (vt) begin
                  refOverrun = 1'b1;
               end
            end
         endcase
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared = compared + 1;
      if (observed !== expected) begin
         mismatched = mismatched + 1;
         $display("[TB] FAIL %s at %0t: got %0d, expected %0d", tag, $time, observed, expected);
      end
   endtask

   task automatic checkAll();
      checkOutput("drop_req", 32'(drop_req), 32'(refDrop));
      checkOutput("lock_req", 32'(lock_req), 32'(refLock));
      checkOutput("overrun",  32'(overrun),  32'(refOverrun));
      checkOutput("state_o",  32'(state_o),  32'(refPhase));
   endtask

   // Randomize the engine-side inputs for one cycle, then step the model.
   task automatic applyStimulus(input phase_t ph);
      rst       = ($urandom_range(999) < ph.rstPerMille);
      tick_in   = ($urandom_range(99) < ph.tickPct);
      if (ph.levelSel < 0) level = LEVEL_W'($urandom_range(15));
      else                 level = LEVEL_W'(ph.levelSel);
      soft_drop = ($urandom_range(99) < ph.softPct);
      pause     = ($urandom_range(99) < ph.pausePct);
      if ($urandom_range(99) < ph.landFlipPct) landed = ~landed;
      drop_ack  = (drop_req === 1'b1 && $urandom_range(99) < ph.ackPct) || ($urandom_range(99) < 2);
      lock_ack  = (lock_req === 1'b1 && $urandom_range(99) < ph.ackPct) || ($urandom_range(99) < 2);
      modelStep();
   endtask

   initial begin
      phases.push_back('{200, 25,  0,   0,  0, 0, 0, 60, 0});
      phases.push_back('{150, 50,  6,   0,  0, 0, 0, 50, 0});
      phases.push_back('{150, 50, 12,   0,  0, 0, 0, 50, 0});
      phases.push_back('{200, 50,  0, 100,  0, 0, 0, 50, 0});
      phases.push_back('{300, 40,  5,   0,  0, 1, 3, 40, 0});
      phases.push_back('{200, 60, 12,   0,  0, 0, 0,  3, 0});
      phases.push_back('{300, 50,  4,   0, 70, 0, 2, 20, 0});
      phases.push_back('{800, 40, -1,  30, 20, 0, 5, 30, 5});

      rst       = 1'b1;
      tick_in   = 1'b0;
      level     = '0;
      soft_drop = 1'b0;
      pause     = 1'b0;
      landed    = 1'b0;
      drop_ack  = 1'b0;
      lock_ack  = 1'b0;
      modelStep();
      @(negedge clk);
      checkAll();

      foreach (phases[p]) begin
         landed = phases[p].landedStart[0];
         for (int c = 0; c < phases[p].cycles; c++) begin
            applyStimulus(phases[p]);
            @(negedge clk);
            checkAll();
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
